// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: paces snake movement by speed level, handles pause,
// and sequences the death flash before handing control back to IDLE.
module game_tick_scheduler #(
  parameter int unsigned BASE_PERIOD  = 25000000,
  parameter int unsigned STEP         = 2500000,
  parameter int unsigned MIN_PERIOD   = 5000000,
  parameter int unsigned LEVEL_CUBES  = 4,
  parameter int unsigned FLASH_PERIOD = 12500000,
  parameter int unsigned FLASH_COUNT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] game_status,
  input  logic       add_cube,
  input  logic       pause_press,
  output logic       move_tick,
  output logic       flash,
  output logic       die_done,
  output logic [2:0] level,
  output logic       paused
);

  localparam logic [31:0] BASE_W  = 32'(BASE_PERIOD);
  localparam logic [31:0] STEP_W  = 32'(STEP);
  localparam logic [31:0] MIN_W   = 32'(MIN_PERIOD);
  localparam logic [31:0] CUBE_M1 = 32'(LEVEL_CUBES - 1);
  localparam logic [31:0] FPER_M1 = 32'(FLASH_PERIOD - 1);
  localparam logic [31:0] FCNT_M1 = 32'(FLASH_COUNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DYING} state_t;

  state_t      state_q, state_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] apple_q, apple_d;
  logic [2:0]  level_q, level_d;
  logic [31:0] flash_cnt_q, flash_cnt_d;
  logic [31:0] toggle_q, toggle_d;
  logic        move_tick_q, move_tick_d;
  logic        flash_q, flash_d;
  logic        die_done_q, die_done_d;
  logic        paused_q, paused_d;
  logic        game_over;
  logic        wrap;

  // Move period for a level, clamped at MIN_PERIOD without unsigned underflow.
  function automatic logic [31:0] period_of(input logic [2:0] lvl);
    logic [31:0] dec;
    dec = 32'(lvl) * STEP_W;
    if ((BASE_W > MIN_W) && ((BASE_W - MIN_W) > dec)) begin
      return BASE_W - dec;
    end
    return MIN_W;
  endfunction

  assign game_over = (game_status == 2'b00) || (game_status == 2'b11);
  assign wrap      = (tick_cnt_q == period_q - 32'd1);

  // Next-state logic for the FSM, tick pacing, level tracking and death flash.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    period_d    = period_q;
    apple_d     = apple_q;
    level_d     = level_q;
    flash_cnt_d = flash_cnt_q;
    toggle_d    = toggle_q;
    move_tick_d = 1'b0;
    flash_d     = 1'b0;
    die_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (game_status == 2'b10) begin
          state_d    = ST_RUN;
          tick_cnt_d = '0;
          apple_d    = '0;
          level_d    = '0;
          period_d   = period_of(3'd0);
        end
      end
      ST_RUN: begin
        if (game_over)                  state_d = ST_DYING;
        else if (game_status == 2'b01)  state_d = ST_IDLE;
        else if (pause_press)           state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (game_over)                  state_d = ST_DYING;
        else if (game_status == 2'b01)  state_d = ST_IDLE;
        else if (pause_press)           state_d = ST_RUN;
      end
      ST_DYING: begin
        if (die_done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The counter only runs in RUN; a wrap coinciding with leaving RUN is
    // held at period-1 so the tick fires right after resuming instead of
    // being lost.
    if (state_q == ST_RUN) begin
      if (wrap) begin
        if (state_d == ST_RUN) begin
          tick_cnt_d  = '0;
          move_tick_d = 1'b1;
          period_d    = period_of(level_q);
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 32'd1;
      end

      if (add_cube) begin
        if (apple_q == CUBE_M1) begin
          apple_d = '0;
          if (level_q != 3'd7) level_d = level_q + 3'd1;
        end else begin
          apple_d = apple_q + 32'd1;
        end
      end
    end

    // Death flash: light on entry, toggle every FLASH_PERIOD, and replace
    // the final toggle with die_done while forcing the flash dark.
    if (state_d == ST_DYING) begin
      if (state_q != ST_DYING) begin
        flash_d     = 1'b1;
        flash_cnt_d = '0;
        toggle_d    = '0;
      end else begin
        flash_d = flash_q;
        if (flash_cnt_q == FPER_M1) begin
          flash_cnt_d = '0;
          toggle_d    = toggle_q + 32'd1;
          if (toggle_q == FCNT_M1) begin
            flash_d    = 1'b0;
            die_done_d = 1'b1;
          end else begin
            flash_d = ~flash_q;
          end
        end else begin
          flash_cnt_d = flash_cnt_q + 32'd1;
        end
      end
    end
  end

  assign paused_d = (state_d == ST_PAUSE);

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      period_q    <= period_of(3'd0);
      apple_q     <= '0;
      level_q     <= '0;
      flash_cnt_q <= '0;
      toggle_q    <= '0;
      move_tick_q <= 1'b0;
      flash_q     <= 1'b0;
      die_done_q  <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      period_q    <= period_d;
      apple_q     <= apple_d;
      level_q     <= level_d;
      flash_cnt_q <= flash_cnt_d;
      toggle_q    <= toggle_d;
      move_tick_q <= move_tick_d;
      flash_q     <= flash_d;
      die_done_q  <= die_done_d;
      paused_q    <= paused_d;
    end
  end

  assign move_tick = move_tick_q;
  assign flash     = flash_q;
  assign die_done  = die_done_q;
  assign level     = level_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: expected move_tick cycles are queued when
// stimulus is driven and consumed by a negedge monitor as ticks appear.
module tb_game_tick_scheduler;
  localparam int BP = 10, ST = 2, MP = 4, LC = 2, FP = 3, FC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] game_status = 2'b00;
  logic       add_cube = 1'b0;
  logic       pause_press = 1'b0;
  logic       move_tick, flash, die_done, paused;
  logic [2:0] level;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_c;
  int exp_ticks[$];

  game_tick_scheduler #(
    .BASE_PERIOD(BP), .STEP(ST), .MIN_PERIOD(MP),
    .LEVEL_CUBES(LC), .FLASH_PERIOD(FP), .FLASH_COUNT(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_status(game_status), .add_cube(add_cube),
    .pause_press(pause_press), .move_tick(move_tick), .flash(flash),
    .die_done(die_done), .level(level), .paused(paused)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every observed tick must match the queue head.
  always @(negedge clk) begin
    if (move_tick !== 1'b0) begin
      total++;
      if (exp_ticks.size() == 0) begin
        bad++;
        $display("FAIL tick_unexpected: move_tick=%b at cycle %0d, required no tick", move_tick, cyc);
      end else begin
        exp_c = exp_ticks.pop_front();
        if (exp_c != cyc) begin
          bad++;
          $display("FAIL tick_time: tick at cycle %0d, required cycle %0d", cyc, exp_c);
        end else begin
          $display("tick cycle=%0d level=%0d ok", cyc, level);
        end
      end
    end
  end

  task automatic start_game(output int e);
    game_status = 2'b10;
    @(posedge clk); #1;
    e = cyc;
  endtask

  task automatic go_idle();
    game_status = 2'b01; add_cube = 1'b0; pause_press = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    game_status = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    total++; if ({move_tick, flash, die_done, paused} !== 4'b0) begin bad++;
      $display("FAIL reset_flags: got %b, required 0000", {move_tick, flash, die_done, paused}); end
    total++; if (level !== 3'd0) begin bad++;
      $display("FAIL reset_level: got %0d, required 0", level); end
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      game_status = (i < 6) ? 2'b00 : 2'b01;
      @(posedge clk); #1;
      total++; if (flash !== 1'b0 || paused !== 1'b0 || level !== 3'd0) begin bad++;
        $display("FAIL reset_idle: flash=%b paused=%b level=%0d, required 0 0 0", flash, paused, level); end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int e;
    start_game(e);
    exp_ticks.push_back(e + 10); exp_ticks.push_back(e + 20); exp_ticks.push_back(e + 30);
    repeat (35) begin @(posedge clk); #1; end
    total++; if (level !== 3'd0) begin bad++;
      $display("FAIL basic_level: got %0d, required 0", level); end
    total++; if (exp_ticks.size() != 0) begin bad++;
      $display("FAIL basic_ticks: %0d ticks missing, required 0", exp_ticks.size()); end
    exp_ticks.delete();
    go_idle();
    $display("test_basic done");
  endtask

  task automatic test_levels();
    int e;
    int tk[10] = '{10, 16, 20, 24, 28, 32, 36, 40, 44, 48};
    start_game(e);
    foreach (tk[k]) exp_ticks.push_back(e + tk[k]);
    for (int i = 1; i <= 50; i++) begin
      add_cube = ((i >= 2 && i <= 5) || (i >= 11 && i <= 15) || i == 17 ||
                  (i >= 29 && i <= 31) || (i >= 33 && i <= 35) ||
                  (i >= 37 && i <= 39) || i == 41);
      @(posedge clk); #1;
      if (i == 6) begin
        total++; if (level !== 3'd2) begin bad++;
          $display("FAIL level_after4: got %0d, required 2", level); end
      end
      if (i == 18) begin
        total++; if (level !== 3'd5) begin bad++;
          $display("FAIL level_after10: got %0d, required 5", level); end
      end
    end
    add_cube = 1'b0;
    total++; if (level !== 3'd7) begin bad++;
      $display("FAIL level_saturate: got %0d, required 7", level); end
    total++; if (exp_ticks.size() != 0) begin bad++;
      $display("FAIL level_ticks: %0d ticks missing, required 0", exp_ticks.size()); end
    exp_ticks.delete();
    go_idle();
    $display("test_levels done");
  endtask

  task automatic test_pause();
    int e;
    start_game(e);
    exp_ticks.push_back(e + 30); exp_ticks.push_back(e + 38);
    for (int i = 1; i <= 42; i++) begin
      pause_press = (i == 6 || i == 26);
      add_cube = (i == 2 || i == 10 || i == 11 || i == 28);
      @(posedge clk); #1;
      if (i >= 6 && i <= 25) begin
        total++; if (paused !== 1'b1) begin bad++;
          $display("FAIL pause_held: paused=%b at offset %0d, required 1", paused, i); end
      end
      if (i == 26) begin
        total++; if (paused !== 1'b0) begin bad++;
          $display("FAIL pause_resume: paused=%b, required 0", paused); end
      end
      if (i == 27) begin
        total++; if (level !== 3'd0) begin bad++;
          $display("FAIL pause_cube_ignored: level=%0d, required 0", level); end
      end
      if (i == 29) begin
        total++; if (level !== 3'd1) begin bad++;
          $display("FAIL pause_cube_resumed: level=%0d, required 1", level); end
      end
    end
    pause_press = 1'b0; add_cube = 1'b0;
    total++; if (exp_ticks.size() != 0) begin bad++;
      $display("FAIL pause_ticks: %0d ticks missing, required 0", exp_ticks.size()); end
    exp_ticks.delete();
    go_idle();
    $display("test_pause done");
  endtask

  task automatic test_back_to_back();
    int e;
    start_game(e);
    exp_ticks.push_back(e + 10);
    for (int i = 1; i <= 14; i++) begin
      add_cube = (i == 9 || i == 10);
      @(posedge clk); #1;
      if (i == 10) begin
        total++; if (level !== 3'd1) begin bad++;
          $display("FAIL b2b_level: got %0d, required 1", level); end
      end
    end
    add_cube = 1'b0;
    total++; if (exp_ticks.size() != 0) begin bad++;
      $display("FAIL b2b_tick: %0d ticks missing, required 0", exp_ticks.size()); end
    exp_ticks.delete();
    go_idle();
    for (int i = 0; i < 4; i++) begin
      add_cube = 1'b1;
      @(posedge clk); #1;
    end
    add_cube = 1'b0;
    total++; if (level !== 3'd1) begin bad++;
      $display("FAIL idle_cube_ignored: level=%0d, required 1", level); end
    $display("test_back_to_back done");
  endtask

  task automatic test_dying();
    int e;
    int e2;
    logic exp_f;
    start_game(e);
    repeat (3) begin @(posedge clk); #1; end
    game_status = 2'b11; pause_press = 1'b1;
    for (int j = 0; j <= 14; j++) begin
      @(posedge clk); #1;
      pause_press = 1'b0;
      exp_f = (j < 3) || (j >= 6 && j < 9);
      total++; if (flash !== exp_f) begin bad++;
        $display("FAIL dying_flash: flash=%b at step %0d, required %b", flash, j, exp_f); end
      total++; if (die_done !== (j == 12)) begin bad++;
        $display("FAIL dying_done: die_done=%b at step %0d, required %b", die_done, j, (j == 12)); end
      total++; if (paused !== 1'b0) begin bad++;
        $display("FAIL dying_paused: paused=%b at step %0d, required 0", paused, j); end
    end
    start_game(e2);
    exp_ticks.push_back(e2 + 10);
    repeat (12) begin @(posedge clk); #1; end
    total++; if (exp_ticks.size() != 0) begin bad++;
      $display("FAIL dying_restart: %0d ticks missing, required 0", exp_ticks.size()); end
    exp_ticks.delete();
    go_idle();
    $display("test_dying done");
  endtask

  task automatic test_reset_dying();
    int e;
    start_game(e);
    add_cube = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    add_cube = 1'b0;
    game_status = 2'b11;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (flash !== 1'b1 || level !== 3'd1) begin bad++;
      $display("FAIL rd_pre: flash=%b level=%0d, required 1 1", flash, level); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({move_tick, flash, die_done, paused} !== 4'b0 || level !== 3'd0) begin bad++;
      $display("FAIL rd_async: flags=%b level=%0d, required 0000 0", {move_tick, flash, die_done, paused}, level); end
    game_status = 2'b00;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      total++; if (flash !== 1'b0 || die_done !== 1'b0 || level !== 3'd0) begin bad++;
        $display("FAIL rd_idle: flash=%b die_done=%b level=%0d, required 0 0 0", flash, die_done, level); end
    end
    $display("test_reset_dying done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_levels();
    test_pause();
    test_back_to_back();
    test_dying();
    test_reset_dying();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 25000000: move period in clk cycles at level 0.
REQ-002 SHALL have parameter STEP, default 2500000: period reduction per speed level.
REQ-003 SHALL have parameter MIN_PERIOD, default 5000000: lower clamp of the move period.
REQ-004 SHALL have parameter LEVEL_CUBES, default 4: apples eaten per level increment.
REQ-005 SHALL have parameter FLASH_PERIOD, default 12500000: clk cycles per death-flash half-cycle.
REQ-006 SHALL have parameter FLASH_COUNT, default 8: flash toggles before die_done.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port clk, input, 1: system clock.
REQ-009 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-010 SHALL have port game_status, input, 2: 2'b01 start, 2'b10 play, 2'b00/2'b11 over.
REQ-011 SHALL have port add_cube, input, 1: one-cycle apple-eaten pulse.
REQ-012 SHALL have port pause_press, input, 1: one-cycle debounced pause-key pulse.
REQ-013 SHALL have port move_tick, output, 1: one-cycle snake-advance strobe.
REQ-014 SHALL have port flash, output, 1: death-flash level.
REQ-015 SHALL have port die_done, output, 1: one-cycle pulse at flash sequence end.
REQ-016 SHALL have port level, output, 3: current speed level, 0-7.
REQ-017 SHALL have port paused, output, 1: high in PAUSE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, PAUSE, DYING.
REQ-019 IDLE->RUN SHALL occur when game_status==2'b10; on this transition level, tick counter and apple counter SHALL clear.
REQ-020 RUN->PAUSE SHALL occur on pause_press; PAUSE->RUN SHALL occur on pause_press.
REQ-021 RUN or PAUSE->DYING SHALL occur when game_status is 2'b00 or 2'b11; this SHALL take priority over a simultaneous pause_press.
REQ-022 RUN or PAUSE->IDLE SHALL occur when game_status==2'b01.
REQ-023 DYING->IDLE SHALL occur in the cycle after die_done.
REQ-024 In RUN, the tick counter SHALL increment each cycle; at count==period-1 move_tick SHALL pulse for one cycle and the counter SHALL return to 0.
REQ-025 period SHALL be max(BASE_PERIOD - level*STEP, MIN_PERIOD), computed without underflow; it SHALL be sampled at counter wrap only, so a level change takes effect on the following period.
REQ-026 In PAUSE, the tick counter SHALL hold and move_tick SHALL stay 0; resuming SHALL continue from the held count.
REQ-027 The apple counter SHALL count add_cube pulses in RUN only; on reaching LEVEL_CUBES it SHALL clear and level SHALL increment, saturating at 7.
REQ-028 add_cube SHALL be ignored outside RUN.
REQ-029 add_cube and move_tick in the same cycle SHALL both take effect.
REQ-030 On entry to DYING, flash SHALL be set to 1 and a flash counter SHALL start; every FLASH_PERIOD cycles flash SHALL toggle.
REQ-031 After FLASH_COUNT toggles, die_done SHALL pulse for one cycle and flash SHALL be 0.
REQ-032 move_tick, flash and die_done SHALL be 0 in IDLE.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 On rst_n low, at any time including mid-DYING: state=IDLE; move_tick=0, flash=0, die_done=0, level=0, paused=0; all counters=0.
REQ-035 After rst_n deasserts, the FSM SHALL leave IDLE only through REQ-019.

Verification (BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, LEVEL_CUBES=2, FLASH_PERIOD=3, FLASH_COUNT=4)
REQ-036 game_status=2'b10 from reset -> move_tick pulses every 10 cycles, level=0.
REQ-037 4 add_cube pulses in RUN -> level=2; after the next wrap, tick period=6; 10 pulses -> level=5, period clamped at 4; 20 pulses -> level saturates at 7.
REQ-038 pause_press at count 5, hold 20 cycles, pause_press again -> paused high throughout, no move_tick, next tick 4 cycles after resume.
REQ-039 game_status->2'b11 with simultaneous pause_press -> DYING; flash toggles every 3 cycles for 4 toggles, then die_done one cycle, then IDLE.
REQ-040 rst_n low mid-DYING -> all outputs 0 immediately; release with game_status=2'b00 -> stays IDLE.
REQ-041 add_cube in PAUSE or IDLE -> level unchanged.
